// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch core: FSM state encoding,
// BCD nibble width and preload clamping.
package stopwatch_pkg;

    localparam int BCD_W = 4;

    typedef enum logic [1:0] {
        STOP     = 2'd0,
        RUN      = 2'd1,
        LAP_RUN  = 2'd2,
        LAP_STOP = 2'd3
    } sw_state_e;

    // Preload nibbles above 9 are not valid BCD; saturate them to 9.
    function automatic logic [BCD_W-1:0] bcd_clamp(input logic [BCD_W-1:0] nibble);
        return (nibble > 4'd9) ? 4'd9 : nibble;
    endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Control/status bundle between a stopwatch front end and stopwatch_core.
// The master drives the command pulses; the slave (the core) returns the count and status.
interface stopwatch_if #(
    parameter int DIGITS = 4
);
    logic                  i_run;
    logic                  i_clear;
    logic                  i_lap;
    logic                  i_load;
    logic [4*DIGITS-1:0]   i_load_val;
    logic                  i_down;
    logic [4*DIGITS-1:0]   count_bcd;
    logic [4*DIGITS-1:0]   disp_bcd;
    logic                  running;
    logic                  lap_hold;
    logic                  wrap_pulse;
    logic                  done_pulse;

    modport master (
        output i_run, i_clear, i_lap, i_load, i_load_val, i_down,
        input  count_bcd, disp_bcd, running, lap_hold, wrap_pulse, done_pulse
    );

    modport slave (
        input  i_run, i_clear, i_lap, i_load, i_load_val, i_down,
        output count_bcd, disp_bcd, running, lap_hold, wrap_pulse, done_pulse
    );
endinterface

// File: rtl/stopwatch_bcd_digit_cell.sv
// One BCD decade of the ripple counter. When enabled it steps up or down
// and raises co when it rolls over (9->0 up, 0->9 down).
module bcd_digit_cell
    import stopwatch_pkg::*;
(
    input  logic             en,
    input  logic             down,
    input  logic [BCD_W-1:0] d,
    output logic [BCD_W-1:0] q,
    output logic             co
);

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        q  = d;
        co = 1'b0;
        if (en) begin
            if (down) begin
                co = (d == 4'd0);
                q  = co ? 4'd9 : d - 4'd1;
            end else begin
                co = (d == 4'd9);
                q  = co ? 4'd0 : d + 4'd1;
            end
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// Run/stop/clear/lap stopwatch with internal tick prescaler and a DIGITS-wide
// BCD count built from a ripple chain of bcd_digit_cell.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 100,
    parameter int DIGITS  = 4
) (
    input  logic      clk,
    input  logic      reset,
    stopwatch_if.slave bus
);

    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int W   = BCD_W * DIGITS;

    sw_state_e       state_q;
    logic [PW-1:0]   presc_q;
    logic [W-1:0]    count_q;
    logic [W-1:0]    count_d;
    logic [W-1:0]    lap_q;
    logic [W-1:0]    load_clamped;
    logic            wrap_q;
    logic            done_q;
    logic            running;
    logic            lap_hold;
    logic            tick;
    logic [DIGITS:0] carry;
    logic            at_limit;

    assign running  = (state_q == RUN) || (state_q == LAP_RUN);
    assign lap_hold = (state_q == LAP_RUN) || (state_q == LAP_STOP);
    assign tick     = running && (presc_q == PW'(DIV - 1));

    // carry[k] is the rollover out of decade k-1; carry[0] seeds the chain.
    assign carry[0] = 1'b1;

    for (genvar k = 0; k < DIGITS; k++) begin : g_digit
        bcd_digit_cell u_cell (
            .en   (tick & carry[k]),
            .down (bus.i_down),
            .d    (count_q[k*BCD_W +: BCD_W]),
            .q    (count_d[k*BCD_W +: BCD_W]),
            .co   (carry[k+1])
        );
        assign load_clamped[k*BCD_W +: BCD_W] = bcd_clamp(bus.i_load_val[k*BCD_W +: BCD_W]);
    end

    // Rollover out of the top decade: all-9 going up, or all-0 going down.
    assign at_limit = carry[DIGITS];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= STOP;
            presc_q <= '0;
            count_q <= '0;
            lap_q   <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout; later ones in this block override earlier ones.
            wrap_q <= 1'b0;
            done_q <= 1'b0;
            if (bus.i_clear) begin
                state_q <= STOP;
                presc_q <= '0;
                count_q <= '0;
                lap_q   <= '0;
            end else begin
                if (running) begin
                    presc_q <= tick ? '0 : presc_q + PW'(1);
                end
                if (tick) begin
                    if (bus.i_down && at_limit) begin
                        done_q <= 1'b1;
                    end else begin
                        count_q <= count_d;
                        wrap_q  <= !bus.i_down && at_limit;
                    end
                end

                if (bus.i_load) begin
                    if (state_q == STOP) begin
                        count_q <= load_clamped;
                        presc_q <= '0;
                    end
                end else begin
                    unique case (state_q)
                        STOP: begin
                            if (bus.i_run) state_q <= RUN;
                        end
                        RUN: begin
                            if (bus.i_run) begin
                                state_q <= STOP;
                            end else if (bus.i_lap) begin
                                state_q <= LAP_RUN;
                                lap_q   <= count_q;
                            end
                        end
                        LAP_RUN: begin
                            if (bus.i_run)      state_q <= LAP_STOP;
                            else if (bus.i_lap) state_q <= RUN;
                        end
                        LAP_STOP: begin
                            if (bus.i_run)      state_q <= LAP_RUN;
                            else if (bus.i_lap) state_q <= STOP;
                        end
                        default: state_q <= STOP;
                    endcase
                end

                // Countdown exhausted: stop, keeping the lap freeze if one is active.
                if (tick && bus.i_down && at_limit) begin
                    state_q <= lap_hold ? LAP_STOP : STOP;
                end
            end
        end
    end

    assign bus.count_bcd  = count_q;
    assign bus.disp_bcd   = lap_hold ? lap_q : count_q;
    assign bus.running    = running;
    assign bus.lap_hold   = lap_hold;
    assign bus.wrap_pulse = wrap_q;
    assign bus.done_pulse = done_q;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with DIV=10 and two BCD digits.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_stopwatch_core;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    stopwatch_if #(.DIGITS(2)) sw ();

    stopwatch_core #(
        .CLK_HZ  (10),
        .TICK_HZ (1),
        .DIGITS  (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (sw.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_run;
        sw.i_run = 1'b1;
        cyc(1);
        sw.i_run = 1'b0;
    endtask

    task automatic pulse_lap;
        sw.i_lap = 1'b1;
        cyc(1);
        sw.i_lap = 1'b0;
    endtask

    task automatic pulse_clear;
        sw.i_clear = 1'b1;
        cyc(1);
        sw.i_clear = 1'b0;
    endtask

    task automatic pulse_load(input logic [7:0] val);
        sw.i_load     = 1'b1;
        sw.i_load_val = val;
        cyc(1);
        sw.i_load     = 1'b0;
    endtask

    initial begin
        sw.i_run      = 1'b0;
        sw.i_clear    = 1'b0;
        sw.i_lap      = 1'b0;
        sw.i_load     = 1'b0;
        sw.i_load_val = 8'h00;
        sw.i_down     = 1'b0;
        reset         = 1'b1;
        cyc(2);
        check("rst_count", 32'(sw.count_bcd), 32'h00);
        check("rst_disp", 32'(sw.disp_bcd), 32'h00);
        check("rst_flags", {28'd0, sw.running, sw.lap_hold, sw.wrap_pulse, sw.done_pulse}, 32'h0);
        reset = 1'b0;
        cyc(1);

        // Run 25 ticks, then stop and hold.
        pulse_run;
        check("run_running", 32'(sw.running), 32'h1);
        cyc(249);
        check("count_24", 32'(sw.count_bcd), 32'h24);
        cyc(1);
        check("count_25", 32'(sw.count_bcd), 32'h25);
        pulse_run;
        cyc(30);
        check("hold_25", 32'(sw.count_bcd), 32'h25);
        check("stopped", 32'(sw.running), 32'h0);
        pulse_lap;
        check("lap_in_stop_ignored", 32'(sw.lap_hold), 32'h0);

        // Prescaler phase: held at 1, advance to 4, stop, resume -> step after 6 cycles.
        pulse_run;
        cyc(2);
        pulse_run;
        check("phase_stop", 32'(sw.running), 32'h0);
        cyc(5);
        pulse_run;
        cyc(5);
        check("phase_before", 32'(sw.count_bcd), 32'h25);
        cyc(1);
        check("phase_step", 32'(sw.count_bcd), 32'h26);

        // Load 98 and wrap through 99 -> 00 -> 01.
        pulse_clear;
        check("clear_count", 32'(sw.count_bcd), 32'h00);
        check("clear_stop", 32'(sw.running), 32'h0);
        pulse_load(8'h98);
        check("load_98", 32'(sw.count_bcd), 32'h98);
        pulse_run;
        cyc(10);
        check("count_99", 32'(sw.count_bcd), 32'h99);
        cyc(9);
        check("wrap_not_yet", 32'(sw.wrap_pulse), 32'h0);
        cyc(1);
        check("wrap_count", 32'(sw.count_bcd), 32'h00);
        check("wrap_hi", 32'(sw.wrap_pulse), 32'h1);
        cyc(1);
        check("wrap_lo", 32'(sw.wrap_pulse), 32'h0);
        cyc(9);
        check("after_wrap", 32'(sw.count_bcd), 32'h01);
        check("wrap_running", 32'(sw.running), 32'h1);

        // Count down 02 -> 01 -> 00, then done on the following tick.
        pulse_clear;
        sw.i_down = 1'b1;
        pulse_load(8'h02);
        pulse_run;
        cyc(10);
        check("down_01", 32'(sw.count_bcd), 32'h01);
        cyc(10);
        check("down_00", 32'(sw.count_bcd), 32'h00);
        check("done_not_on_reach", 32'(sw.done_pulse), 32'h0);
        cyc(9);
        check("still_running", 32'(sw.running), 32'h1);
        cyc(1);
        check("done_hi", 32'(sw.done_pulse), 32'h1);
        check("done_count", 32'(sw.count_bcd), 32'h00);
        check("done_stopped", 32'(sw.running), 32'h0);
        cyc(1);
        check("done_lo", 32'(sw.done_pulse), 32'h0);
        pulse_load(8'hA3);
        check("load_clamp", 32'(sw.count_bcd), 32'h93);
        sw.i_down = 1'b0;

        // Lap freeze, lap-stop, release.
        pulse_clear;
        pulse_load(8'h10);
        pulse_run;
        cyc(3);
        pulse_lap;
        check("lap_hold", 32'(sw.lap_hold), 32'h1);
        check("lap_disp", 32'(sw.disp_bcd), 32'h10);
        cyc(6);
        check("lap_live", 32'(sw.count_bcd), 32'h11);
        check("lap_frozen", 32'(sw.disp_bcd), 32'h10);
        pulse_run;
        check("lapstop_flags", {30'd0, sw.running, sw.lap_hold}, 32'h1);
        check("lapstop_disp", 32'(sw.disp_bcd), 32'h10);
        pulse_lap;
        check("release_flags", {30'd0, sw.running, sw.lap_hold}, 32'h0);
        check("release_disp", 32'(sw.disp_bcd), 32'h11);

        // Clear beats load and run when all arrive together in RUN.
        pulse_clear;
        pulse_load(8'h55);
        pulse_run;
        cyc(3);
        sw.i_clear    = 1'b1;
        sw.i_load     = 1'b1;
        sw.i_run      = 1'b1;
        sw.i_load_val = 8'h77;
        cyc(1);
        sw.i_clear = 1'b0;
        sw.i_load  = 1'b0;
        sw.i_run   = 1'b0;
        check("prio_count", 32'(sw.count_bcd), 32'h00);
        check("prio_stop", 32'(sw.running), 32'h0);

        // Asynchronous reset between clock edges.
        pulse_run;
        cyc(15);
        check("pre_reset", 32'(sw.count_bcd), 32'h01);
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        check("async_count", 32'(sw.count_bcd), 32'h00);
        check("async_flags", {28'd0, sw.running, sw.lap_hold, sw.wrap_pulse, sw.done_pulse}, 32'h0);
        cyc(2);
        reset = 1'b0;
        cyc(3);
        check("post_reset_idle", {24'd0, sw.count_bcd}, 32'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
